// File: rtl/tick_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// tick_scheduler_pkg: shared 12 MHz prescale constants, channel mode, widths
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tick_scheduler_pkg;

  localparam int T_1US   = 12;
  localparam int T_100US = 1200;
  localparam int T_1MS   = 12000;
  localparam int T_10MS  = 120000;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  // Index/counter width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_scheduler_if.sv
// ---------------------------------------------------------------------------
// tick_scheduler_if: configuration, start/stop and event bundle of the scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface tick_scheduler_if
  import tick_scheduler_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 16
);

  localparam int CW = idx_width(NCH);

  logic           cfg_we;
  logic [CW-1:0]  cfg_ch;
  logic [W-1:0]   cfg_period;
  logic           cfg_oneshot;
  logic [NCH-1:0] start;
  logic [NCH-1:0] stop;
  logic           base_tick;
  logic [NCH-1:0] tick_out;
  logic [NCH-1:0] active;

  modport master (
    output cfg_we, cfg_ch, cfg_period, cfg_oneshot, start, stop,
    input  base_tick, tick_out, active
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_period, cfg_oneshot, start, stop,
    output base_tick, tick_out, active
  );

endinterface

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler: modulo-PRESC counter producing the shared 1-clk base tick
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tick_prescaler
  import tick_scheduler_pkg::*;
#(
  parameter int PRESC = T_100US
) (
  input  logic clk,
  input  logic rst,
  output logic o_base_tick
);

  localparam int             PW     = idx_width(PRESC);
  localparam logic [PW-1:0]  c_LAST = PW'(PRESC - 1);

  logic [PW-1:0] r_pre;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
    end else if (r_pre == c_LAST) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // Decoded from the registered count; held low while reset is asserted.
  assign o_base_tick = (r_pre == c_LAST) && !rst;

endmodule

`default_nettype wire

// File: rtl/tick_scheduler.sv
// ---------------------------------------------------------------------------
// tick_scheduler: NCH periodic/one-shot pulse channels sharing one prescaler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int PRESC = T_100US,
  parameter int NCH   = 4,
  parameter int W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  tick_scheduler_if.slave bus
);

  localparam int CW = idx_width(NCH);

  logic w_base_tick;

  tick_prescaler #(
    .PRESC (PRESC)
  ) u_prescaler (
    .clk         (clk),
    .rst         (rst),
    .o_base_tick (w_base_tick)
  );

  assign bus.base_tick = w_base_tick;

  for (genvar i = 0; i < NCH; i++) begin : g_ch

    logic         w_wr;
    logic [W-1:0] w_eff_period;
    mode_e        w_eff_mode;

    logic [W-1:0] r_period;
    logic [W-1:0] r_count;
    mode_e        r_mode;
    logic         r_active;
    logic         r_tick;

    // Out-of-range indices can never match a channel number, so they drop out here.
    assign w_wr         = bus.cfg_we && (bus.cfg_ch == CW'(i));
    assign w_eff_period = w_wr ? bus.cfg_period : r_period;
    assign w_eff_mode   = w_wr ? mode_e'(bus.cfg_oneshot) : r_mode;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_period <= '0;
        r_count  <= '0;
        r_mode   <= MODE_PERIODIC;
        r_active <= 1'b0;
        r_tick   <= 1'b0;
      end else begin
        r_tick <= 1'b0;
        if (w_wr) begin
          r_period <= bus.cfg_period;
          r_mode   <= mode_e'(bus.cfg_oneshot);
        end
        if (bus.stop[i]) begin
          r_active <= 1'b0;
          r_count  <= '0;
        end else if (bus.start[i]) begin
          // A start with zero period leaves the channel exactly as it was.
          if (w_eff_period != '0) begin
            r_active <= 1'b1;
            r_count  <= w_eff_period - W'(1);
          end
        end else if (r_active && w_base_tick) begin
          if (r_count != '0) begin
            r_count <= r_count - W'(1);
          end else begin
            r_tick <= 1'b1;
            if ((w_eff_mode == MODE_ONESHOT) || (r_period == '0)) begin
              r_active <= 1'b0;
            end else begin
              r_count <= r_period - W'(1);
            end
          end
        end
      end
    end

    assign bus.tick_out[i] = r_tick;
    assign bus.active[i]   = r_active;

  end

endmodule

`default_nettype wire

// File: tb/tb_tick_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tick_scheduler: directed checks of prescaler, channel modes, start/stop and reset
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tick_scheduler;

  localparam int PRESC = 4;
  localparam int NCH   = 5;
  localparam int W     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tick_scheduler_if #(.NCH(NCH), .W(W)) bus ();

  tick_scheduler #(
    .PRESC (PRESC),
    .NCH   (NCH),
    .W     (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.cfg_we      = 1'b0;
    bus.cfg_ch      = '0;
    bus.cfg_period  = '0;
    bus.cfg_oneshot = 1'b0;
    bus.start       = '0;
    bus.stop        = '0;
  endtask

  task automatic cfg(input int ch, input int period, input bit oneshot);
    bus.cfg_we      = 1'b1;
    bus.cfg_ch      = ch[2:0];
    bus.cfg_period  = period[W-1:0];
    bus.cfg_oneshot = oneshot;
    step();
    bus.cfg_we      = 1'b0;
  endtask

  // Leaves the bench at a sample point where base_tick is high.
  task automatic sync_bt();
    for (int k = 0; (k < 2 * PRESC + 2) && (bus.base_tick !== 1'b1); k++) step();
    n_tests++;
    if (bus.base_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_bt: base_tick=%b, required 1 within budget", bus.base_tick);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (3) step();
    n_tests++;
    if (bus.tick_out !== '0 || bus.active !== '0 || bus.base_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: tick_out=%b active=%b base_tick=%b, required all 0",
               bus.tick_out, bus.active, bus.base_tick);
    end
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      logic exp_bt;
      step();
      exp_bt = ((k % PRESC) == PRESC - 1);
      n_tests++;
      if (bus.base_tick !== exp_bt) begin
        n_fail++;
        $display("FAIL base_tick k=%0d: got %b, required %b", k, bus.base_tick, exp_bt);
      end
    end
  endtask

  task automatic test_periodic();
    cfg(0, 3, 1'b0);
    sync_bt();
    bus.start = 5'b00001;
    for (int k = 1; k <= 40; k++) begin
      logic exp_t;
      step();
      bus.start = '0;
      exp_t = (k == 13) || (k == 25) || (k == 37);
      n_tests++;
      if (bus.tick_out[0] !== exp_t || bus.active[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL ch0_periodic k=%0d: tick=%b active=%b, required tick=%b active=1",
                 k, bus.tick_out[0], bus.active[0], exp_t);
      end
    end
  endtask

  task automatic test_oneshot();
    cfg(1, 2, 1'b1);
    sync_bt();
    bus.start = 5'b00010;
    for (int k = 1; k <= 50; k++) begin
      logic exp_t, exp_a;
      step();
      bus.start = '0;
      exp_t = (k == 9);
      exp_a = (k < 9);
      n_tests++;
      if (bus.tick_out[1] !== exp_t || bus.active[1] !== exp_a) begin
        n_fail++;
        $display("FAIL ch1_oneshot k=%0d: tick=%b active=%b, required tick=%b active=%b",
                 k, bus.tick_out[1], bus.active[1], exp_t, exp_a);
      end
    end
  endtask

  task automatic test_zero_period_and_writethrough();
    bus.start = 5'b00100;
    step();
    bus.start = '0;
    for (int k = 1; k <= 2; k++) begin
      n_tests++;
      if (bus.active[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL ch2_zero_period k=%0d: active=%b, required 0", k, bus.active[2]);
      end
      step();
    end
    sync_bt();
    bus.cfg_we      = 1'b1;
    bus.cfg_ch      = 3'd2;
    bus.cfg_period  = 16'd1;
    bus.cfg_oneshot = 1'b0;
    bus.start       = 5'b00100;
    for (int k = 1; k <= 12; k++) begin
      logic exp_t;
      step();
      bus.cfg_we = 1'b0;
      bus.start  = '0;
      exp_t = (k == 5) || (k == 9);
      n_tests++;
      if (bus.tick_out[2] !== exp_t || bus.active[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL ch2_writethrough k=%0d: tick=%b active=%b, required tick=%b active=1",
                 k, bus.tick_out[2], bus.active[2], exp_t);
      end
    end
  endtask

  task automatic test_stop_restart();
    bus.stop  = 5'b00001;
    bus.start = 5'b00001;
    step();
    bus.stop  = '0;
    bus.start = '0;
    for (int k = 1; k <= 16; k++) begin
      n_tests++;
      if (bus.active[0] !== 1'b0 || bus.tick_out[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL ch0_stop k=%0d: active=%b tick=%b, required 0 0",
                 k, bus.active[0], bus.tick_out[0]);
      end
      step();
    end
    sync_bt();
    bus.start = 5'b00001;
    for (int k = 1; k <= 24; k++) begin
      logic exp_t;
      step();
      bus.start = '0;
      exp_t = (k == 21);
      n_tests++;
      if (bus.tick_out[0] !== exp_t || bus.active[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL ch0_restart k=%0d: tick=%b active=%b, required tick=%b active=1",
                 k, bus.tick_out[0], bus.active[0], exp_t);
      end
      if (k == 8) bus.start = 5'b00001;
    end
  endtask

  task automatic test_bad_channel();
    cfg(5, 1, 1'b0);
    n_tests++;
    if (bus.active !== 5'b00101) begin
      n_fail++;
      $display("FAIL bad_ch_active: active=%b, required 00101", bus.active);
    end
    sync_bt();
    bus.start = 5'b00010;
    for (int k = 1; k <= 16; k++) begin
      logic exp_t, exp_a;
      step();
      bus.start = '0;
      exp_t = (k == 9);
      exp_a = (k < 9);
      n_tests++;
      if (bus.tick_out[1] !== exp_t || bus.active[1] !== exp_a) begin
        n_fail++;
        $display("FAIL bad_ch_ch1 k=%0d: tick=%b active=%b, required tick=%b active=%b",
                 k, bus.tick_out[1], bus.active[1], exp_t, exp_a);
      end
    end
  endtask

  task automatic test_reset_active();
    cfg(3, 5, 1'b0);
    cfg(4, 5, 1'b0);
    bus.start = 5'b11111;
    step();
    bus.start = '0;
    n_tests++;
    if (bus.active !== 5'b11111) begin
      n_fail++;
      $display("FAIL all_active: active=%b, required 11111", bus.active);
    end
    rst = 1'b1;
    step();
    n_tests++;
    if (bus.active !== '0 || bus.tick_out !== '0 || bus.base_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_active: active=%b tick_out=%b base_tick=%b, required all 0",
               bus.active, bus.tick_out, bus.base_tick);
    end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      logic exp_bt;
      step();
      exp_bt = (k == 3);
      n_tests++;
      if (bus.base_tick !== exp_bt || bus.active !== '0) begin
        n_fail++;
        $display("FAIL reset_restart k=%0d: base_tick=%b active=%b, required %b 00000",
                 k, bus.base_tick, bus.active, exp_bt);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_periodic();
    test_oneshot();
    test_zero_period_and_writethrough();
    test_stop_restart();
    test_bad_channel();
    test_reset_active();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
